// File: rtl/neuron_mac.sv
// rtl/neuron_mac.sv - streaming multi-beat MAC neuron with bias, ReLU and saturation
module neuron_mac #(
  parameter int DW    = 5,
  parameter int LANES = 4,
  parameter int BEATS = 4,
  parameter int OUT_W = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DW-1:0]     in_data,
  input  logic [LANES*DW-1:0]     in_weight,
  input  logic [OUT_W-1:0]        bias,
  input  logic                    relu_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_sat
);

  localparam int PW    = 2 * DW;
  localparam int AW0   = 2 * DW + $clog2(LANES * BEATS);
  localparam int ACC_W = ((AW0 > OUT_W) ? AW0 : OUT_W) + 2;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {ST_ACCUM, ST_DRAIN, ST_OUT} state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            beat_cnt_q, beat_cnt_d;
  logic signed [PW-1:0]     prod_q [LANES];
  logic signed [PW-1:0]     prod_d [LANES];
  logic                     pvld_q, pvld_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [OUT_W-1:0]  bias_q, bias_d;
  logic                     relu_q, relu_d;
  logic                     out_valid_q, out_valid_d;
  logic [OUT_W-1:0]         out_data_q, out_data_d;
  logic                     out_sat_q, out_sat_d;

  logic                     accept;
  logic signed [DW-1:0]     d_lane [LANES];
  logic signed [DW-1:0]     w_lane [LANES];
  logic signed [ACC_W-1:0]  prod_sum;
  logic signed [ACC_W-1:0]  final_v;

  assign in_ready  = (state_q == ST_ACCUM);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  always_comb begin
    prod_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      d_lane[i] = in_data[i*DW +: DW];
      w_lane[i] = in_weight[i*DW +: DW];
      prod_sum  = prod_sum + ACC_W'(prod_q[i]);
    end
    // ReLU is applied before clipping so a clamped zero never reports saturation
    final_v = acc_q + prod_sum + ACC_W'(bias_q);
    if (relu_q && final_v[ACC_W-1]) begin
      final_v = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    prod_d      = prod_q;
    pvld_d      = accept;
    acc_d       = acc_q;
    bias_d      = bias_q;
    relu_d      = relu_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    if (accept) begin
      for (int i = 0; i < LANES; i++) begin
        prod_d[i] = PW'(d_lane[i]) * PW'(w_lane[i]);
      end
    end

    if (pvld_q && state_q != ST_DRAIN) begin
      acc_d = acc_q + prod_sum;
    end

    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          if (beat_cnt_q == '0) begin
            bias_d = bias;
            relu_d = relu_en;
          end
          if (beat_cnt_q == CW'(BEATS - 1)) begin
            beat_cnt_d = '0;
            state_d    = ST_DRAIN;
          end else begin
            beat_cnt_d = beat_cnt_q + CW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (final_v > SAT_MAX) begin
          out_data_d = {1'b0, {(OUT_W-1){1'b1}}};
          out_sat_d  = 1'b1;
        end else if (final_v < SAT_MIN) begin
          out_data_d = {1'b1, {(OUT_W-1){1'b0}}};
          out_sat_d  = 1'b1;
        end else begin
          out_data_d = final_v[OUT_W-1:0];
          out_sat_d  = 1'b0;
        end
        out_valid_d = 1'b1;
        acc_d       = '0;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACCUM;
      beat_cnt_q  <= '0;
      for (int i = 0; i < LANES; i++) begin
        prod_q[i] <= '0;
      end
      pvld_q      <= 1'b0;
      acc_q       <= '0;
      bias_q      <= '0;
      relu_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      prod_q      <= prod_d;
      pvld_q      <= pvld_d;
      acc_q       <= acc_d;
      bias_q      <= bias_d;
      relu_q      <= relu_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// tb/tb_neuron_mac.sv - self-checking bench for neuron_mac
module tb_neuron_mac;
  localparam int DW = 5, LANES = 4, BEATS = 4, OUT_W = 12, NV = LANES * BEATS;
  localparam int SMAX = (1 << (OUT_W - 1)) - 1;
  localparam int SMIN = -(1 << (OUT_W - 1));

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [LANES*DW-1:0] in_data = '0;
  logic [LANES*DW-1:0] in_weight = '0;
  logic [OUT_W-1:0]    bias = '0;
  logic                relu_en = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [OUT_W-1:0]    out_data;
  logic                out_sat;

  neuron_mac #(.DW(DW), .LANES(LANES), .BEATS(BEATS), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_weight(in_weight), .bias(bias), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    d;
    int    w;
    int    b;
    bit    r;
    int    gap;
    int    hold;
    int    exp_d;
    int    exp_s;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   cur_d[NV];
  int   cur_w[NV];
  int   cur_bias;
  bit   cur_relu;
  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_junk();
    in_data   = (LANES*DW)'($urandom);
    in_weight = (LANES*DW)'($urandom);
    bias      = OUT_W'($urandom);
    relu_en   = 1'($urandom);
  endtask

  function automatic int sout();
    return int'($signed(out_data));
  endfunction

  // Reference: whole-vector dot product, bias, optional ReLU, clamp
  task automatic model(output int od, output int os);
    longint s = 0;
    for (int k = 0; k < NV; k++) s += longint'(cur_d[k] * cur_w[k]);
    s += cur_bias;
    if (cur_relu && s < 0) s = 0;
    if (s > SMAX) begin od = SMAX; os = 1; end
    else if (s < SMIN) begin od = SMIN; os = 1; end
    else begin od = int'(s); os = 0; end
  endtask

  task automatic drive_beat(input int b);
    int guard = 0;
    while (!in_ready && guard < 10) begin
      in_valid = 1'b0;
      step();
      guard++;
    end
    chk("beat_in_ready", int'(in_ready), 1);
    in_valid = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      in_data[i*DW +: DW]   = DW'(cur_d[b*LANES+i]);
      in_weight[i*DW +: DW] = DW'(cur_w[b*LANES+i]);
    end
    if (b == 0) begin
      bias    = OUT_W'(cur_bias);
      relu_en = cur_relu;
    end else begin
      bias    = OUT_W'($urandom);
      relu_en = ~cur_relu;
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input string tag, input int exp_d, input int exp_s,
                         input int gapmax, input int hold);
    int g;
    logic [OUT_W-1:0] held;
    out_ready = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      g = int'($urandom_range(gapmax));
      repeat (g) begin
        in_valid = 1'b0;
        drive_junk();
        step();
      end
      drive_beat(b);
    end
    drive_junk();
    chk({tag, "_valid_drain"}, int'(out_valid), 0);
    chk({tag, "_in_ready_drain"}, int'(in_ready), 0);
    step();
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_data"}, sout(), exp_d);
    chk({tag, "_sat"}, int'(out_sat), exp_s);
    held = out_data;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      drive_junk();
      step();
      chk({tag, "_hold_in_ready"}, int'(in_ready), 0);
      chk({tag, "_hold_valid"}, int'(out_valid), 1);
      chk({tag, "_hold_data"}, int'(out_data), int'(held));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_valid_after_hs"}, int'(out_valid), 0);
    chk({tag, "_in_ready_after_hs"}, int'(in_ready), 1);
  endtask

  task automatic fill(input int d, input int w, input int b, input bit r);
    for (int k = 0; k < NV; k++) begin
      cur_d[k] = d;
      cur_w[k] = w;
    end
    cur_bias = b;
    cur_relu = r;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ed, es;
    tbl[0] = '{"nominal",    3,   2,  0, 1'b0, 0, 0,   96, 0};
    tbl[1] = '{"bubbles",    3,   2,  0, 1'b0, 3, 5,   96, 0};
    tbl[2] = '{"sat_pos",  -16, -16,  0, 1'b0, 0, 0, 2047, 1};
    tbl[3] = '{"sat_neg",  -16,  15,  0, 1'b0, 0, 0,-2048, 1};
    tbl[4] = '{"relu_on",   -1,   5, 10, 1'b1, 1, 2,    0, 0};
    tbl[5] = '{"relu_off",  -1,   5, 10, 1'b0, 0, 0,  -70, 0};

    #2 rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      drive_junk();
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_sat", int'(out_sat), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      @(posedge clk);
    end
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    step();
    chk("post_rst_out_valid", int'(out_valid), 0);
    chk("post_rst_out_data", int'(out_data), 0);
    chk("post_rst_in_ready", int'(in_ready), 1);

    foreach (tbl[i]) begin
      fill(tbl[i].d, tbl[i].w, tbl[i].b, tbl[i].r);
      run_vec(tbl[i].name, tbl[i].exp_d, tbl[i].exp_s, tbl[i].gap, tbl[i].hold);
    end

    for (int n = 0; n < 25; n++) begin
      for (int k = 0; k < NV; k++) begin
        cur_d[k] = int'($urandom_range(31)) - 16;
        cur_w[k] = int'($urandom_range(31)) - 16;
      end
      cur_bias = int'($urandom_range(4095)) - 2048;
      cur_relu = 1'($urandom);
      model(ed, es);
      run_vec("random", ed, es, int'($urandom_range(2)), int'($urandom_range(3)));
    end

    fill(-16, -16, 100, 1'b0);
    drive_beat(0);
    drive_beat(1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    fill(3, 2, 0, 1'b0);
    run_vec("after_midrst", 96, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
